burst_lock_scheduler: RTL and testbench
=======================================

BURST_LOCK_SCHEDULER -- requirements
Module: burst_lock_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..16).
REQ-002 Parameter MAX_BURST, default 16, maximum accepted beats per grant tenure (1..256).
REQ-003 Parameter ID_W, default $clog2(NUM_REQ), width of grant_id.
REQ-004 clk  input  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 req  input  NUM_REQ  per-requester access request, level, held for the whole tenure.
REQ-007 last  input  NUM_REQ  per-requester end-of-burst marker, qualified by beat.
REQ-008 beat  input  1  shared resource accepted one beat from the current owner this cycle.
REQ-009 grant  output  NUM_REQ  registered one-hot ownership vector.
REQ-010 grant_valid  output  1  OR of grant.
REQ-011 grant_id  output  ID_W  binary index of owner; 0 when grant_valid=0.
REQ-012 beat_count  output  $clog2(MAX_BURST+1)  beats accepted in current tenure.
REQ-013 release  output  1  one-cycle pulse in the cycle a tenure ends.

Function
REQ-014 FSM states IDLE, OWN, GAP.
REQ-015 Priority uses an NUM_REQ x NUM_REQ LRU matrix: prio[i][j]=1 means i beats j.
REQ-016 The winner is the i with req[i]=1 and prio[i][j]=1 for every j!=i with req[j]=1; at most one winner.
REQ-017 On grant issue to k: row k cleared, column k set (k becomes lowest priority); the matrix is otherwise unchanged.
REQ-018 IDLE: if req!=0 at a clock edge, grant takes the winner one-hot and the FSM enters OWN; req seen in cycle t gives grant in cycle t+1.
REQ-019 OWN: each beat=1 cycle increments beat_count by 1.
REQ-020 OWN: the tenure ends when beat=1 and last[owner]=1, when beat=1 and beat_count+1==MAX_BURST, or when req[owner]=0.
REQ-021 At tenure end, release pulses in that cycle, and the FSM enters GAP at the next edge with grant=0 and beat_count=0.
REQ-022 GAP lasts exactly one cycle; at its end the FSM arbitrates as in IDLE (to OWN if req!=0, else IDLE); minimum new grant is 2 cycles after the release cycle.
REQ-023 When last and MAX_BURST termination coincide, the block produces one release, and beat_count never exceeds MAX_BURST.
REQ-024 Owner req drop counts as a release; any beat in that same cycle is still counted toward beat_count before clearing.
REQ-025 beat in IDLE or GAP, and last from non-owners, are ignored.
REQ-026 Requests arriving during OWN do not preempt the owner.
REQ-027 grant, grant_id and grant_valid change only at clock edges, and grant is never multi-hot.

Reset
REQ-028 Reset forces IDLE, grant=0, grant_id=0, grant_valid=0, beat_count=0 and release=0, and sets prio[i][j]=1 for i<j and 0 otherwise.
REQ-029 Reset asserted mid-tenure drops grant immediately (asynchronously), and the next arbitration uses the reset matrix.

Structure
REQ-030 A shared package holds the state enum (IDLE/OWN/GAP) and a onehot-to-index function.
REQ-031 The LRU matrix with its winner logic and update port is a sub-module named lru_priority_matrix; the FSM and counter sit in burst_lock_scheduler.

Verification (NUM_REQ=4, MAX_BURST=4)
REQ-032 Reset release, then req=4'b1111 -> grant=0001 in next cycle; after each release, the following grants are 0010, 0100, 1000, 0001.
REQ-033 Owner 2, beat on 2 cycles with last on the 2nd -> release on 2nd beat, grant=0 for 1 cycle, beat_count=2 before clearing.
REQ-034 Owner 0 never asserts last, beat every cycle -> release on 4th beat, beat_count peaks at 4, then GAP.
REQ-035 Owner 1 drops req mid-burst while req[3]=1 -> release that cycle, GAP, then grant=1000.
REQ-036 beat with last on 4th beat simultaneously -> exactly one release pulse; req[3] asserted during OWN of 0 -> no preemption.
REQ-037 Reset asserted while in OWN with beat_count=3 -> outputs zero asynchronously, then req=4'b1010 -> grant=0010.

Source files
------------

// File: rtl/burst_lock_scheduler_pkg.sv
// Shared types and helpers for the burst lock scheduler.
package burst_lock_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Binary index of a one-hot vector up to 16 requesters; zero vector maps to 0.
  function automatic logic [3:0] onehot_to_index(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) begin
        idx = idx | 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/burst_lock_scheduler_lru.sv
// Least-recently-granted priority matrix: prio[i][j]=1 means requester i beats j.
module lru_priority_matrix #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  input  logic [NUM_REQ-1:0] update_grant,
  output logic [NUM_REQ-1:0] winner
);

  logic [NUM_REQ-1:0] prio [NUM_REQ];

  // The granted requester drops below everyone: its row clears, its column sets.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          prio[i][j] <= (i < j);
        end
      end
    end else if (update) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          prio[i][j] <= (prio[i][j] | update_grant[j]) & ~update_grant[i];
        end
      end
    end
  end

  // A requester wins when it beats every other active requester.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      winner[i] = req[i];
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i) begin
          winner[i] = winner[i] & (~req[j] | prio[i][j]);
        end else begin
          winner[i] = winner[i];
        end
      end
    end
  end

endmodule

// File: rtl/burst_lock_scheduler.sv
// Grants a shared resource to one requester for a burst tenure, with LRU arbitration
// and a one-cycle gap between tenures.
module burst_lock_scheduler
  import burst_lock_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               last,
  input  logic                             beat,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             grant_valid,
  output logic [ID_W-1:0]                  grant_id,
  output logic [$clog2(MAX_BURST+1)-1:0]   beat_count,
  output logic                             release_pulse
);

  localparam int CW = $clog2(MAX_BURST + 1);

  state_t            state;
  logic [CW-1:0]     count_r;
  logic [NUM_REQ-1:0] winner;
  logic [ID_W-1:0]   winner_id;
  logic              arb_fire;
  logic              owner_req;
  logic              owner_last;
  logic              burst_full;
  logic              tenure_end;
  logic              own_beat;

  assign arb_fire   = ((state == IDLE) || (state == GAP)) && (|req);
  assign winner_id  = ID_W'(onehot_to_index(16'(winner)));
  assign owner_req  = |(req & grant);
  assign owner_last = |(last & grant);
  assign burst_full = (32'(count_r) == (MAX_BURST - 1));
  assign own_beat   = (state == OWN) && beat;
  assign tenure_end = (state == OWN) && (!owner_req || (beat && (owner_last || burst_full)));

  // The count shown includes this cycle's accepted beat, so the final beat is visible.
  assign beat_count    = count_r + CW'(own_beat);
  assign release_pulse = tenure_end;

  lru_priority_matrix #(
    .NUM_REQ (NUM_REQ)
  ) u_lru (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .update       (arb_fire),
    .update_grant (winner),
    .winner       (winner)
  );

  // Tenure FSM: arbitration in IDLE/GAP, beat counting and termination in OWN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      count_r     <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          count_r <= '0;
          if (arb_fire) begin
            state       <= OWN;
            grant       <= winner;
            grant_valid <= 1'b1;
            grant_id    <= winner_id;
          end else begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
          end
        end
        OWN: begin
          if (tenure_end) begin
            state       <= GAP;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            count_r     <= '0;
          end else if (beat) begin
            count_r <= count_r + CW'(1);
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          state       <= IDLE;
          grant       <= '0;
          grant_valid <= 1'b0;
          grant_id    <= '0;
          count_r     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_burst_lock_scheduler.sv
// Self-checking bench for burst_lock_scheduler (NUM_REQ=4, MAX_BURST=4) with a grant scoreboard.
module tb_burst_lock_scheduler;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic         beat;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_id;
  logic [2:0]   beat_count;
  logic         release_pulse;

  int checks   = 0;
  int failures = 0;

  logic [N-1:0] exp_q [$];
  bit           mp [N][N];

  burst_lock_scheduler #(
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .last          (last),
    .beat          (beat),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .beat_count    (beat_count),
    .release_pulse (release_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mp[i][j] = (i < j);
  endtask

  // Reference arbitration: pick the requester beating all others, then demote it.
  task automatic model_arbitrate(input logic [N-1:0] r);
    logic [N-1:0] w;
    int k;
    w = '0;
    k = -1;
    for (int i = 0; i < N; i++) begin
      bit ok;
      ok = r[i];
      for (int j = 0; j < N; j++)
        if (j != i && r[j] && !mp[i][j]) ok = 0;
      if (ok) begin
        w[i] = 1'b1;
        k = i;
      end
    end
    if (k >= 0) begin
      for (int j = 0; j < N; j++) begin
        mp[k][j] = 0;
        if (j != k) mp[j][k] = 1;
      end
    end
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    last = '0;
    beat = 1'b0;
    model_reset();
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_grant got=%b/%b/%0d exp=0000/0/0", grant, grant_valid, grant_id);
    end
    checks++;
    if (beat_count !== 3'd0 || release_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_count got=%0d/%b exp=0/0", beat_count, release_pulse);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] e;
    logic [N-1:0] table_exp [5];
    table_exp[0] = 4'b0001; table_exp[1] = 4'b0010; table_exp[2] = 4'b0100;
    table_exp[3] = 4'b1000; table_exp[4] = 4'b0001;
    req = 4'b1111;
    model_arbitrate(req);
    tick();
    for (int n = 0; n < 5; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (grant !== e || grant !== table_exp[n] || grant_id !== 2'(n % 4) || grant_valid !== 1'b1) begin
        failures++;
        $display("FAIL rot_grant[%0d] got=%b id=%0d exp=%b id=%0d", n, grant, grant_id, table_exp[n], n % 4);
      end
      if (n == 4) break;
      beat = 1'b1;
      last = 4'b1111;
      #1;
      checks++;
      if (release_pulse !== 1'b1 || beat_count !== 3'd1) begin
        failures++;
        $display("FAIL rot_release[%0d] got=%b/%0d exp=1/1", n, release_pulse, beat_count);
      end
      tick();
      beat = 1'b0;
      last = '0;
      #1;
      checks++;
      if (grant !== 4'b0000 || release_pulse !== 1'b0 || beat_count !== 3'd0) begin
        failures++;
        $display("FAIL rot_gap[%0d] got=%b/%b/%0d exp=0000/0/0", n, grant, release_pulse, beat_count);
      end
      model_arbitrate(req);
      tick();
    end
    req = 4'b0000;
    #1;
    checks++;
    if (release_pulse !== 1'b1) begin
      failures++;
      $display("FAIL rot_drop_release got=%b exp=1", release_pulse);
    end
    tick();
    tick();
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      failures++;
      $display("FAIL rot_idle got=%b/%b exp=0000/0", grant, grant_valid);
    end
  endtask

  task automatic test_last_burst();
    logic [N-1:0] e;
    req = 4'b0100;
    model_arbitrate(req);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL lb_grant got=%b id=%0d exp=%b id=2", grant, grant_id, e);
    end
    beat = 1'b1;
    last = 4'b1011;
    #1;
    checks++;
    if (beat_count !== 3'd1 || release_pulse !== 1'b0) begin
      failures++;
      $display("FAIL lb_beat1 got=%0d/%b exp=1/0", beat_count, release_pulse);
    end
    tick();
    last = 4'b0100;
    #1;
    checks++;
    if (beat_count !== 3'd2 || release_pulse !== 1'b1) begin
      failures++;
      $display("FAIL lb_beat2 got=%0d/%b exp=2/1", beat_count, release_pulse);
    end
    tick();
    last = '0;
    req = 4'b0000;
    #1;
    checks++;
    if (grant !== 4'b0000 || beat_count !== 3'd0 || release_pulse !== 1'b0) begin
      failures++;
      $display("FAIL lb_gap got=%b/%0d/%b exp=0000/0/0", grant, beat_count, release_pulse);
    end
    tick();
    checks++;
    if (grant !== 4'b0000 || beat_count !== 3'd0) begin
      failures++;
      $display("FAIL lb_idle_beat got=%b/%0d exp=0000/0", grant, beat_count);
    end
    beat = 1'b0;
  endtask

  task automatic test_max_burst();
    logic [N-1:0] e;
    int rel_seen;
    req = 4'b0001;
    model_arbitrate(req);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || e !== 4'b0001) begin
      failures++;
      $display("FAIL mb_grant got=%b exp=%b", grant, e);
    end
    beat = 1'b1;
    last = 4'b1110;
    rel_seen = 0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      checks++;
      if (beat_count !== 3'(k) || release_pulse !== (k == 4)) begin
        failures++;
        $display("FAIL mb_beat[%0d] got=%0d/%b exp=%0d/%b", k, beat_count, release_pulse, k, (k == 4));
      end
      if (k == 4) model_arbitrate(req);
      tick();
    end
    checks++;
    if (grant !== 4'b0000 || beat_count !== 3'd0) begin
      failures++;
      $display("FAIL mb_gap got=%b/%0d exp=0000/0", grant, beat_count);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || beat_count !== 3'd1) begin
      failures++;
      $display("FAIL mb_regrant got=%b/%0d exp=%b/1", grant, beat_count, e);
    end
    beat = 1'b0;
    last = '0;
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_req_drop();
    logic [N-1:0] e;
    req = 4'b0010;
    model_arbitrate(req);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || e !== 4'b0010) begin
      failures++;
      $display("FAIL rd_grant got=%b exp=%b", grant, e);
    end
    req = 4'b1010;
    beat = 1'b1;
    tick();
    checks++;
    if (grant !== 4'b0010) begin
      failures++;
      $display("FAIL rd_nopreempt got=%b exp=0010", grant);
    end
    req = 4'b1000;
    #1;
    checks++;
    if (release_pulse !== 1'b1 || beat_count !== 3'd2) begin
      failures++;
      $display("FAIL rd_drop got=%b/%0d exp=1/2", release_pulse, beat_count);
    end
    tick();
    beat = 1'b0;
    model_arbitrate(req);
    #1;
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL rd_gap got=%b exp=0000", grant);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || e !== 4'b1000 || grant_id !== 2'd3) begin
      failures++;
      $display("FAIL rd_next got=%b id=%0d exp=1000 id=3", grant, grant_id);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_coincide();
    logic [N-1:0] e;
    int rel_cnt;
    req = 4'b0001;
    model_arbitrate(req);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || e !== 4'b0001) begin
      failures++;
      $display("FAIL co_grant got=%b exp=%b", grant, e);
    end
    req = 4'b1001;
    beat = 1'b1;
    rel_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      last = (k == 4) ? 4'b0001 : 4'b0000;
      #1;
      if (release_pulse === 1'b1) rel_cnt++;
      checks++;
      if (grant !== 4'b0001 || beat_count !== 3'(k)) begin
        failures++;
        $display("FAIL co_own[%0d] got=%b/%0d exp=0001/%0d", k, grant, beat_count, k);
      end
      if (k == 4) model_arbitrate(req);
      tick();
    end
    last = '0;
    beat = 1'b0;
    if (release_pulse === 1'b1) rel_cnt++;
    checks++;
    if (rel_cnt !== 1 || grant !== 4'b0000) begin
      failures++;
      $display("FAIL co_single_release got=%0d/%b exp=1/0000", rel_cnt, grant);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || e !== 4'b1000) begin
      failures++;
      $display("FAIL co_next got=%b exp=%b", grant, e);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] e;
    req = 4'b0100;
    model_arbitrate(req);
    tick();
    e = exp_q.pop_front();
    beat = 1'b1;
    tick();
    tick();
    tick();
    beat = 1'b0;
    #1;
    checks++;
    if (grant !== e || beat_count !== 3'd3) begin
      failures++;
      $display("FAIL rm_pre got=%b/%0d exp=%b/3", grant, beat_count, e);
    end
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0 || beat_count !== 3'd0) begin
      failures++;
      $display("FAIL rm_async got=%b/%b/%0d/%0d exp=0000/0/0/0", grant, grant_valid, grant_id, beat_count);
    end
    model_reset();
    req = 4'b1010;
    #1;
    reset = 1'b0;
    model_arbitrate(req);
    tick();
    e = exp_q.pop_front();
    checks++;
    if (grant !== e || e !== 4'b0010) begin
      failures++;
      $display("FAIL rm_after got=%b exp=%b", grant, e);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    last = '0;
    beat = 1'b0;
    do_reset();
    test_reset();
    test_rotation();
    test_last_burst();
    test_max_burst();
    test_req_drop();
    do_reset();
    test_coincide();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
